// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the Wishbone command master.
// Holds the FSM state encoding, response status codes and bus widths.
package wb_cmd_master_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    STS_OK      = 2'b00,
    STS_ERR     = 2'b01,
    STS_RTY_EXH = 2'b10,
    STS_TIMEOUT = 2'b11
  } status_t;

endpackage

// File: rtl/wb_cmd_master.sv
// Single-command Wishbone classic master with retry/backoff and a per-attempt wait timeout.
// All bus and response outputs are registered; one command is in flight at a time.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// BUS     | cyc/stb asserted, waiting for ack/err/rty or timeout
// BACKOFF | one idle bus cycle after rty before reissuing the same access
// RESP    | response held on rsp_* until rsp_ready
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [SEL_W-1:0]  cmd_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_status,
  output logic              wb_cycle,
  output logic              wb_strobe,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [SEL_W-1:0]  wb_sel,
  output logic [2:0]        wb_cti,
  output logic [1:0]        wb_bte,
  input  logic              wb_ack,
  input  logic              wb_err,
  input  logic              wb_rty,
  input  logic [DATA_W-1:0] wb_rdata
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [2:0] RETRY_MAX   = 3'(MAX_RETRY);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic [2:0] retry_cnt;

  assign wb_cti = 3'b000;
  assign wb_bte = 2'b00;

  always_comb begin
    wait_nxt = wait_cnt + 8'd1;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_status <= STS_OK;
      wb_cycle   <= 1'b0;
      wb_strobe  <= 1'b0;
      wb_we      <= 1'b0;
      wb_addr    <= '0;
      wb_wdata   <= '0;
      wb_sel     <= '0;
      wait_cnt   <= '0;
      retry_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            wb_we     <= cmd_we;
            wb_addr   <= cmd_addr;
            wb_wdata  <= cmd_wdata;
            wb_sel    <= cmd_sel;
            wb_cycle  <= 1'b1;
            wb_strobe <= 1'b1;
            cmd_ready <= 1'b0;
            wait_cnt  <= '0;
            retry_cnt <= '0;
            state     <= ST_BUS;
          end
        end

        // Priority ack > err > rty; any of them beats a same-cycle timeout.
        ST_BUS: begin
          if (wb_ack) begin
            rsp_rdata  <= wb_we ? '0 : wb_rdata;
            rsp_status <= STS_OK;
            rsp_valid  <= 1'b1;
            wb_cycle   <= 1'b0;
            wb_strobe  <= 1'b0;
            state      <= ST_RESP;
          end else if (wb_err) begin
            rsp_rdata  <= '0;
            rsp_status <= STS_ERR;
            rsp_valid  <= 1'b1;
            wb_cycle   <= 1'b0;
            wb_strobe  <= 1'b0;
            state      <= ST_RESP;
          end else if (wb_rty) begin
            wb_cycle  <= 1'b0;
            wb_strobe <= 1'b0;
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 3'd1;
              state     <= ST_BACKOFF;
            end else begin
              rsp_rdata  <= '0;
              rsp_status <= STS_RTY_EXH;
              rsp_valid  <= 1'b1;
              state      <= ST_RESP;
            end
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == TIMEOUT_CNT) begin
              rsp_rdata  <= '0;
              rsp_status <= STS_TIMEOUT;
              rsp_valid  <= 1'b1;
              wb_cycle   <= 1'b0;
              wb_strobe  <= 1'b0;
              state      <= ST_RESP;
            end
          end
        end

        ST_BACKOFF: begin
          wb_cycle  <= 1'b1;
          wb_strobe <= 1'b1;
          wait_cnt  <= '0;
          state     <= ST_BUS;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: a scripted Wishbone slave plus a
// scoreboard of expected responses computed from each slave plan.
module tb_wb_cmd_master;
  import wb_cmd_master_pkg::*;

  localparam int K_ACK    = 0;
  localparam int K_ERR    = 1;
  localparam int K_RTY    = 2;
  localparam int K_NONE   = 3;
  localparam int K_ACKERR = 4;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic        wb_cycle, wb_strobe, wb_we;
  logic [7:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic        wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0;
  logic [31:0] wb_rdata = JUNK;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  status;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  int          plan_kind[8];
  int          plan_wait[8];
  logic [31:0] plan_data;
  int          exp_len[8];
  int          exp_nb;

  wb_cmd_master #(.TIMEOUT(255), .MAX_RETRY(3)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .wb_cycle(wb_cycle), .wb_strobe(wb_strobe), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_sel(wb_sel),
    .wb_cti(wb_cti), .wb_bte(wb_bte),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty), .wb_rdata(wb_rdata)
  );

  always #5 wb_clk = ~wb_clk;

  // Reference model: walk the slave plan and derive burst lengths and the final response.
  task automatic predict(input logic we, output exp_t e);
    int  retries = 0;
    bit  fin = 0;
    e = '0;
    exp_nb = 0;
    for (int b = 0; b < 8 && !fin; b++) begin
      exp_len[b] = (plan_kind[b] == K_NONE) ? 255 : plan_wait[b] + 1;
      exp_nb = b + 1;
      case (plan_kind[b])
        K_ACK, K_ACKERR: begin e.status = 2'b00; e.rdata = we ? 32'h0 : plan_data; fin = 1; end
        K_ERR:           begin e.status = 2'b01; e.rdata = 32'h0; fin = 1; end
        K_NONE:          begin e.status = 2'b11; e.rdata = 32'h0; fin = 1; end
        default: begin
          if (retries < 3) retries++;
          else begin e.status = 2'b10; e.rdata = 32'h0; fin = 1; end
        end
      endcase
    end
  endtask

  task automatic run_txn(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input int hold);
    exp_t e, got;
    int   b = 0, c = 0, gap = 0;
    bit   prev = 0, done = 0;
    logic [31:0] r0;
    logic [1:0]  s0;
    predict(we, e);
    sb.push_back(e);
    @(negedge wb_clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL accept_ready: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_sel = sel;
    @(negedge wb_clk);
    cmd_valid = 1'b0; cmd_we = ~we; cmd_addr = 8'($urandom); cmd_wdata = $urandom; cmd_sel = 4'($urandom);
    n_cmp++;
    if (wb_cycle !== 1'b1 || wb_strobe !== 1'b1) begin
      n_fail++; $display("FAIL cyc_after_accept: got cyc=%b stb=%b want 1/1", wb_cycle, wb_strobe);
    end
    for (int t = 0; t < 2000 && !done; t++) begin
      if (wb_cycle) begin
        if (!prev && b > 0) begin
          n_cmp++;
          if (gap != 1) begin n_fail++; $display("FAIL backoff_gap: got %0d want 1", gap); end
        end
        c++;
        n_cmp++;
        if (wb_addr !== addr || wb_we !== we || wb_wdata !== wdata || wb_sel !== sel || wb_strobe !== 1'b1) begin
          n_fail++;
          $display("FAIL bus_fields: got a=%h we=%b d=%h s=%h stb=%b want a=%h we=%b d=%h s=%h stb=1",
                   wb_addr, wb_we, wb_wdata, wb_sel, wb_strobe, addr, we, wdata, sel);
        end
        wb_ack = 0; wb_err = 0; wb_rty = 0; wb_rdata = JUNK;
        if (b < 8 && plan_kind[b] != K_NONE && c == plan_wait[b] + 1) begin
          case (plan_kind[b])
            K_ACK:    begin wb_ack = 1; wb_rdata = plan_data; end
            K_ERR:    wb_err = 1;
            K_RTY:    wb_rty = 1;
            default:  begin wb_ack = 1; wb_err = 1; wb_rdata = plan_data; end
          endcase
        end
        prev = 1;
      end else begin
        wb_ack = 0; wb_err = 0; wb_rty = 0; wb_rdata = JUNK;
        if (prev) begin
          n_cmp++;
          if (b >= 8 || c != exp_len[b]) begin
            n_fail++; $display("FAIL burst_len[%0d]: got %0d want %0d", b, c, (b < 8) ? exp_len[b] : -1);
          end
          b++; c = 0; gap = 0;
        end
        gap++;
        prev = 0;
        if (rsp_valid) done = 1;
      end
      if (!done) @(negedge wb_clk);
    end
    n_cmp++;
    if (!done) begin
      n_fail++; $display("FAIL rsp_timeout: got no rsp_valid want rsp_valid within 2000 cycles");
    end
    n_cmp++;
    if (b != exp_nb) begin n_fail++; $display("FAIL burst_count: got %0d want %0d", b, exp_nb); end
    r0 = rsp_rdata; s0 = rsp_status;
    for (int h = 0; h < hold; h++) begin
      @(negedge wb_clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || rsp_status !== s0 || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL rsp_hold: got v=%b d=%h s=%b rdy=%b want v=1 d=%h s=%b rdy=0",
                 rsp_valid, rsp_rdata, rsp_status, cmd_ready, r0, s0);
      end
    end
    got = sb.pop_front();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== got.rdata || rsp_status !== got.status) begin
      n_fail++;
      $display("FAIL rsp_data: got v=%b d=%h s=%b want v=1 d=%h s=%b",
               rsp_valid, rsp_rdata, rsp_status, got.rdata, got.status);
    end
    rsp_ready = 1'b1;
    @(negedge wb_clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rsp_handshake: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic set_plan1(input int k, input int w);
    plan_kind[0] = k; plan_wait[0] = w;
  endtask

  task automatic test_reset();
    wb_rst = 1'b1;
    repeat (3) @(negedge wb_clk);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    n_cmp++;
    if (cmd_ready !== 1 || rsp_valid !== 0 || rsp_rdata !== 0 || rsp_status !== 0) begin
      n_fail++; $display("FAIL reset_rsp: got rdy=%b v=%b d=%h s=%b want 1 0 0 0", cmd_ready, rsp_valid, rsp_rdata, rsp_status);
    end
    n_cmp++;
    if (wb_cycle !== 0 || wb_strobe !== 0 || wb_we !== 0 || wb_addr !== 0 || wb_wdata !== 0 ||
        wb_sel !== 0 || wb_cti !== 0 || wb_bte !== 0) begin
      n_fail++; $display("FAIL reset_bus: got cyc=%b stb=%b we=%b a=%h d=%h s=%h cti=%b bte=%b want all 0",
                         wb_cycle, wb_strobe, wb_we, wb_addr, wb_wdata, wb_sel, wb_cti, wb_bte);
    end
  endtask

  task automatic test_read();
    set_plan1(K_ACK, 2); plan_data = 32'hDEAD_BEEF;
    run_txn(1'b0, 8'h10, 32'h0, 4'hF, 0);
  endtask

  task automatic test_write();
    set_plan1(K_ACK, 0); plan_data = 32'h5555_AAAA;
    run_txn(1'b1, 8'h04, 32'h1234_5678, 4'hF, 0);
  endtask

  task automatic test_error();
    set_plan1(K_ERR, 1); plan_data = 32'h0;
    run_txn(1'b0, 8'h20, 32'h0, 4'h3, 0);
  endtask

  task automatic test_retry();
    plan_kind[0] = K_RTY; plan_wait[0] = 0;
    plan_kind[1] = K_RTY; plan_wait[1] = 1;
    plan_kind[2] = K_ACK; plan_wait[2] = 1;
    plan_data = 32'hCAFE_F00D;
    run_txn(1'b0, 8'h30, 32'h0, 4'hF, 0);
    for (int i = 0; i < 4; i++) begin plan_kind[i] = K_RTY; plan_wait[i] = 0; end
    run_txn(1'b1, 8'h34, 32'hA5A5_0F0F, 4'hC, 0);
  endtask

  task automatic test_timeout();
    set_plan1(K_NONE, 0);
    run_txn(1'b0, 8'h40, 32'h0, 4'hF, 0);
    set_plan1(K_ACK, 254); plan_data = 32'h0000_00FF;
    run_txn(1'b0, 8'h44, 32'h0, 4'hF, 0);
  endtask

  task automatic test_ack_err_hold();
    set_plan1(K_ACKERR, 0); plan_data = 32'h0BAD_F00D;
    run_txn(1'b0, 8'h50, 32'h0, 4'h1, 10);
  endtask

  task automatic test_ignore_idle();
    @(negedge wb_clk);
    wb_ack = 1; wb_err = 1; wb_rty = 1; wb_rdata = 32'h1111_2222;
    @(negedge wb_clk);
    wb_ack = 0; wb_err = 0; wb_rty = 0; wb_rdata = JUNK;
    repeat (2) begin
      n_cmp++;
      if (rsp_valid !== 0 || cmd_ready !== 1 || wb_cycle !== 0) begin
        n_fail++; $display("FAIL idle_ignore: got v=%b rdy=%b cyc=%b want 0 1 0", rsp_valid, cmd_ready, wb_cycle);
      end
      @(negedge wb_clk);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      set_plan1(($urandom_range(0, 1) == 0) ? K_ACK : K_ERR, $urandom_range(0, 4));
      plan_data = $urandom;
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom, 4'($urandom), 0);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge wb_clk);
    cmd_valid = 1; cmd_we = 0; cmd_addr = 8'h60; cmd_sel = 4'hF;
    @(negedge wb_clk);
    cmd_valid = 0;
    repeat (2) @(negedge wb_clk);
    #1 wb_rst = 1'b1;
    #1;
    n_cmp++;
    if (wb_cycle !== 0 || wb_strobe !== 0) begin
      n_fail++; $display("FAIL rst_async_cyc: got cyc=%b stb=%b want 0 0", wb_cycle, wb_strobe);
    end
    @(negedge wb_clk);
    wb_rst = 1'b0;
    repeat (3) begin
      @(negedge wb_clk);
      n_cmp++;
      if (rsp_valid !== 0 || cmd_ready !== 1 || wb_cycle !== 0) begin
        n_fail++; $display("FAIL rst_mid_after: got v=%b rdy=%b cyc=%b want 0 1 0", rsp_valid, cmd_ready, wb_cycle);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_error();
    test_retry();
    test_timeout();
    test_ack_err_hold();
    test_ignore_idle();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum bus cycles per attempt awaiting ack/err/rty; legal range 1..255.
REQ-002 Parameter MAX_RETRY, default 3: reissues allowed after wb_rty; legal range 0..7.
REQ-003 wb_clk  in  1  single clock; all logic rising-edge.
REQ-004 wb_rst  in  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
REQ-007 cmd_we  in  1  1=write, 0=read.
REQ-008 cmd_addr  in  8  register byte address.
REQ-009 cmd_wdata  in  32  write data.
REQ-010 cmd_sel  in  4  byte enables.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid&rsp_ready.
REQ-013 rsp_rdata  out  32  read data; 0 for writes and failures.
REQ-014 rsp_status  out  2  00 ok, 01 bus error, 10 retry exhausted, 11 timeout.
REQ-015 wb_cycle, wb_strobe, wb_we  out  1 each  Wishbone classic master controls.
REQ-016 wb_addr  out  8; wb_wdata  out  32; wb_sel  out  4  Wishbone address, data, byte enables.
REQ-017 wb_cti  out  3 fixed 000; wb_bte  out  2 fixed 00.
REQ-018 wb_ack, wb_err, wb_rty  in  1 each; wb_rdata  in  32  slave response.

Function
REQ-019 States IDLE, BUS, BACKOFF, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-020 Accept in IDLE latches cmd fields and moves to BUS; wb_cycle=wb_strobe=1 from the next cycle, all wb outputs registered.
REQ-021 In BUS, wb_addr/wb_wdata/wb_sel/wb_we SHALL be held constant from the latched command.
REQ-022 Response sampled in BUS priority: wb_ack > wb_err > wb_rty when asserted together.
REQ-023 wb_ack: capture wb_rdata (reads only), status 00, go RESP; wb_cycle/wb_strobe low and rsp_valid high the cycle after ack.
REQ-024 wb_err: status 01, rdata 0, go RESP.
REQ-025 wb_rty with retry count < MAX_RETRY: increment count, go BACKOFF (cyc/stb low exactly one cycle), then return to BUS with identical fields.
REQ-026 wb_rty with retry count = MAX_RETRY: status 10, go RESP; MAX_RETRY=0 fails on first rty.
REQ-027 8-bit wait counter clears on entry to BUS, increments each BUS cycle with no response; reaching TIMEOUT drops cyc/stb, status 11, go RESP.
REQ-028 A response on the same cycle the counter reaches TIMEOUT SHALL win over timeout.
REQ-029 RESP holds rsp_valid, rsp_rdata, rsp_status stable until rsp_ready; on handshake go IDLE, new command acceptable the following cycle.
REQ-030 Retry count clears on each command accept.
REQ-031 Slave responses outside BUS SHALL be ignored.

Reset
REQ-032 wb_rst asynchronously forces IDLE; cmd_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_status=00, wb_cycle=wb_strobe=wb_we=0, wb_addr=0, wb_wdata=0, wb_sel=0, counters=0.
REQ-033 Reset mid-transaction SHALL abandon it with no response emitted; wb_cycle drops asynchronously.

Structure
REQ-034 Shared package holds state enum, status codes (OK, ERR, RTY_EXH, TIMEOUT), and widths ADDR_W=8, DATA_W=32, SEL_W=4.
REQ-035 Single flat module; no sub-module needed.

Verification
REQ-036 Read addr 0x10, slave acks after 2 wait cycles with 0xDEADBEEF -> one 3-cycle cyc/stb, rsp_rdata=0xDEADBEEF, status 00.
REQ-037 Write addr 0x04 data 0x12345678 sel 0xF, immediate ack -> wb_we=1, wb_wdata=0x12345678, status 00, rdata 0.
REQ-038 Slave returns rty twice then ack (MAX_RETRY=3) -> three cyc/stb bursts separated by 1 idle cycle, status 00; rty four times -> status 10 after 4th.
REQ-039 No slave response, TIMEOUT=255 -> cyc/stb high exactly 255 cycles, status 11; ack on cycle 255 -> status 00.
REQ-040 ack+err asserted together -> status 00; rsp_ready held low 10 cycles -> rsp_valid/rsp_status stable, cmd_ready 0 throughout.
REQ-041 wb_rst pulsed while in BUS -> wb_cycle low same cycle, no rsp_valid, cmd_ready=1 after release.
